// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - ResultSrc encodings seen in the EX stage
//   - EX operand forwarding select encodings
//   - data-memory handshake FSM states
//   - fwd_select(): forwarding priority for one EX source operand
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

    // EX result select encodings (ResultSrcE)
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    // Forwarding mux selects for the EX operands
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Data-memory handshake FSM
    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // The younger producer (MEM) wins over the older one (WB); x0 is never
    // forwarded because it is hard-wired to zero.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/hazard_mem_fsm.sv
// ---------------------------------------------------------------------------
// hazard_mem_fsm
// Request/acknowledge handshake to a variable-latency data memory with an
// optional wait timeout and a sticky error flag.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mem_access_i    MEM stage holds a load or store
//   mem_ack_i       memory completes the access this cycle
//   mem_req_o       request to the data memory (0 while rst is high)
//   mem_err_o       sticky timeout flag
//
// Parameter TIMEOUT: WAIT cycles allowed before the access is abandoned;
// 0 disables the timeout.
// ---------------------------------------------------------------------------
import hazard_ctrl_pkg::*;

module hazard_mem_fsm #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_access_i,
    input  logic mem_ack_i,
    output logic mem_req_o,
    output logic mem_err_o
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

    mem_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;
    logic              mem_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MEM_IDLE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        abort_d    = 1'b0;
        mem_req    = 1'b0;

        unique case (state_q)
            MEM_IDLE: begin
                // abort_q masks the request for the one cycle after a
                // timeout, which releases the stalled pipeline instead of
                // re-issuing the abandoned access.
                mem_req = mem_access_i & ~abort_q;
                if (mem_req && !mem_ack_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack_i) begin
                    state_d    = MEM_IDLE;
                    wait_cnt_d = '0;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_V)) begin
                    state_d    = MEM_IDLE;
                    wait_cnt_d = '0;
                    err_d      = 1'b1;
                    abort_d    = 1'b1;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // Reset must drop the request immediately, even if MEM still holds an access.
    assign mem_req_o = mem_req & ~rst;
    assign mem_err_o = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard control for a 5-stage pipeline: EX operand forwarding, load-use and
// memory-wait stalls, branch flushes, data-memory handshake and saturating
// stall/flush performance counters.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   rs1_d_i, rs2_d_i                 source registers in ID
//   rs1_e_i, rs2_e_i, rd_e_i         source/destination registers in EX
//   result_src_e_i                   EX result select (RES_MEM = load)
//   pc_src_e_i                       taken branch/jump resolved in EX
//   rd_m_i, reg_write_m_i            MEM destination and write enable
//   mem_access_m_i                   MEM holds a load or store
//   rd_w_i, reg_write_w_i            WB destination and write enable
//   mem_ack_m_i                      data memory completes the access
//   mem_req_m_o                      data memory request
//   stall_f_o/_d_o/_e_o/_m_o         hold the stage register
//   flush_d_o/_e_o/_w_o              synchronous clear of the stage register
//   forward_ae_o, forward_be_o       EX operand forwarding selects
//   mem_err_o                        sticky memory-timeout flag
//   stall_cnt_o, flush_cnt_o         saturating performance counters
// ---------------------------------------------------------------------------
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d_i,
    input  logic [4:0]       rs2_d_i,
    input  logic [4:0]       rs1_e_i,
    input  logic [4:0]       rs2_e_i,
    input  logic [4:0]       rd_e_i,
    input  logic [1:0]       result_src_e_i,
    input  logic             pc_src_e_i,
    input  logic [4:0]       rd_m_i,
    input  logic             reg_write_m_i,
    input  logic             mem_access_m_i,
    input  logic [4:0]       rd_w_i,
    input  logic             reg_write_w_i,
    input  logic             mem_ack_m_i,
    output logic             mem_req_m_o,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             stall_m_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             flush_w_o,
    output logic [1:0]       forward_ae_o,
    output logic [1:0]       forward_be_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic             lw_stall;
    logic             mem_stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    hazard_mem_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_mem_fsm (
        .clk         (clk),
        .rst         (rst),
        .mem_access_i(mem_access_m_i),
        .mem_ack_i   (mem_ack_m_i),
        .mem_req_o   (mem_req_m_o),
        .mem_err_o   (mem_err_o)
    );

    assign forward_ae_o = fwd_select(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
    assign forward_be_o = fwd_select(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);

    assign lw_stall  = (result_src_e_i == RES_MEM) && (rd_e_i != 5'd0) &&
                       ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
    assign mem_stall = mem_req_m_o & ~mem_ack_m_i;

    always_comb begin
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        stall_e_o = 1'b0;
        stall_m_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        flush_w_o = 1'b0;

        if (rst) begin
            // Stage controls stay quiet while reset is held.
        end else if (mem_stall) begin
            // Freeze everything up to MEM and push a bubble into WB. ID and EX
            // are not flushed, so a branch or load there is re-evaluated once
            // the memory releases the pipeline.
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            stall_m_o = 1'b1;
            flush_w_o = 1'b1;
        end else begin
            // A taken branch kills the load-use pair in ID, so the fetch
            // stage must not be held: the PC has to take the target now.
            stall_f_o = lw_stall & ~pc_src_e_i;
            stall_d_o = lw_stall & ~pc_src_e_i;
            flush_d_o = pc_src_e_i;
            flush_e_o = lw_stall | pc_src_e_i;
        end
    end

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_d_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
